// File: rtl/layer1_pkg.sv
// Shared constants, derived widths and state encoding for the layer-1 convolution scheduler.
package layer1_pkg;

  localparam int FILTER_SIZE = 25;
  localparam int GROUP_NUM   = 16;
  localparam int TILE_NUM    = 36;
  localparam int RD_LAT      = 1;
  localparam int CAP_LAT     = 1;
  localparam int W_AW        = 9;
  localparam int F_AW        = 10;

  localparam int GROUP_W = $clog2(GROUP_NUM);
  localparam int TILE_W  = $clog2(TILE_NUM);
  localparam int TAP_W   = $clog2(FILTER_SIZE);
  localparam int CAP_W   = (CAP_LAT > 1) ? $clog2(CAP_LAT) : 1;

  // IDLE wait start | FETCH tap reads | WAIT array busy | CAPT capture delay | EMIT word handshake
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT,
    ST_CAPT,
    ST_EMIT
  } state_e;

endpackage

// File: rtl/layer1_tap_counter.sv
// Nested tap / tile / group counter; tile is the inner word loop, group the outer one.
module layer1_tap_counter
  import layer1_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               clr_i,
  input  logic               tap_inc_i,
  input  logic               word_inc_i,
  output logic [TAP_W-1:0]   tap_o,
  output logic [TILE_W-1:0]  tile_o,
  output logic [GROUP_W-1:0] group_o,
  output logic               tap_last_o,
  output logic               tile_last_o,
  output logic               group_last_o
);

  logic [TAP_W-1:0]   tap_q, tap_d;
  logic [TILE_W-1:0]  tile_q, tile_d;
  logic [GROUP_W-1:0] group_q, group_d;

  assign tap_last_o   = (tap_q == TAP_W'(FILTER_SIZE - 1));
  assign tile_last_o  = (tile_q == TILE_W'(TILE_NUM - 1));
  assign group_last_o = (group_q == GROUP_W'(GROUP_NUM - 1));

  always_comb begin
    tap_d   = tap_q;
    tile_d  = tile_q;
    group_d = group_q;
    if (clr_i) begin
      tap_d   = '0;
      tile_d  = '0;
      group_d = '0;
    end else begin
      if (tap_inc_i) begin
        tap_d = tap_last_o ? '0 : tap_q + 1'b1;
      end
      if (word_inc_i) begin
        if (tile_last_o) begin
          tile_d  = '0;
          group_d = group_last_o ? '0 : group_q + 1'b1;
        end else begin
          tile_d = tile_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      tap_q   <= '0;
      tile_q  <= '0;
      group_q <= '0;
    end else begin
      tap_q   <= tap_d;
      tile_q  <= tile_d;
      group_q <= group_d;
    end
  end

  assign tap_o   = tap_q;
  assign tile_o  = tile_q;
  assign group_o = group_q;

endmodule

// File: rtl/layer1_conv_sched.sv
// Layer-1 conv array sequencer: streams tap reads per (group, tile), waits for the
// array, then hands each result word downstream over valid/ready.
module layer1_conv_sched
  import layer1_pkg::*;
(
  input  logic               clk_in_i,
  input  logic               rst_n_i,
  input  logic               start_i,
  input  logic               abort_i,
  output logic               w_rd_en_o,
  output logic [W_AW-1:0]    w_rd_addr_o,
  output logic               f_rd_en_o,
  output logic [F_AW-1:0]    f_rd_addr_o,
  output logic               conv_start_o,
  input  logic               conv_ready_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [GROUP_W-1:0] out_group_o,
  output logic [TILE_W-1:0]  out_tile_o,
  output logic               busy_o,
  output logic               done_o,
  output logic               err_early_o
);

  if (GROUP_NUM * FILTER_SIZE > (1 << W_AW)) begin : g_w_aw_chk
    $error("W_AW cannot address GROUP_NUM*FILTER_SIZE weights");
  end
  if (TILE_NUM * FILTER_SIZE > (1 << F_AW)) begin : g_f_aw_chk
    $error("F_AW cannot address TILE_NUM*FILTER_SIZE features");
  end
  if (RD_LAT < 1 || RD_LAT > 3) begin : g_rd_lat_chk
    $error("RD_LAT must be 1..3");
  end

  state_e             state_q, state_d;
  logic [CAP_W-1:0]   cap_q, cap_d;
  logic [RD_LAT-1:0]  cs_q, cs_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               ctr_clr, tap_inc, word_inc;
  logic               fetch, emit, tap0_rd;
  logic [TAP_W-1:0]   tap;
  logic [TILE_W-1:0]  tile;
  logic [GROUP_W-1:0] group;
  logic               tap_last, tile_last, group_last;

  layer1_tap_counter u_ctr (
    .clk_i        (clk_in_i),
    .rst_n_i      (rst_n_i),
    .clr_i        (ctr_clr),
    .tap_inc_i    (tap_inc),
    .word_inc_i   (word_inc),
    .tap_o        (tap),
    .tile_o       (tile),
    .group_o      (group),
    .tap_last_o   (tap_last),
    .tile_last_o  (tile_last),
    .group_last_o (group_last)
  );

  assign fetch   = (state_q == ST_FETCH);
  assign emit    = (state_q == ST_EMIT);
  assign tap0_rd = fetch && (tap == '0);

  always_comb begin
    state_d  = state_q;
    cap_d    = cap_q;
    ctr_clr  = 1'b0;
    tap_inc  = 1'b0;
    word_inc = 1'b0;
    done_d   = 1'b0;
    err_d    = err_q | (conv_ready_i && (state_q != ST_WAIT));
    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_FETCH;
          ctr_clr = 1'b1;
        end
      end
      ST_FETCH: begin
        tap_inc = 1'b1;
        if (tap_last) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (conv_ready_i) begin
          state_d = ST_CAPT;
          cap_d   = CAP_W'(CAP_LAT - 1);
        end
      end
      ST_CAPT: begin
        if (cap_q == '0) state_d = ST_EMIT;
        else cap_d = cap_q - 1'b1;
      end
      ST_EMIT: begin
        if (out_ready_i) begin
          word_inc = 1'b1;
          if (tile_last && group_last) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_FETCH;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (abort_i) begin
      state_d  = ST_IDLE;
      done_d   = 1'b0;
      ctr_clr  = 1'b1;
      tap_inc  = 1'b0;
      word_inc = 1'b0;
    end
    // delay line lines conv_start up with tap-0 data coming out of the buffers
    cs_d = abort_i ? '0 : ((cs_q << 1) | RD_LAT'(tap0_rd));
  end

  always_ff @(posedge clk_in_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
      cap_q   <= '0;
      cs_q    <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cap_q   <= cap_d;
      cs_q    <= cs_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign w_rd_en_o    = fetch;
  assign f_rd_en_o    = fetch;
  assign w_rd_addr_o  = fetch ? (W_AW'(group) * W_AW'(FILTER_SIZE) + W_AW'(tap)) : '0;
  assign f_rd_addr_o  = fetch ? (F_AW'(tile) * F_AW'(FILTER_SIZE) + F_AW'(tap)) : '0;
  assign conv_start_o = cs_q[RD_LAT-1];
  assign out_valid_o  = emit;
  assign out_group_o  = emit ? group : '0;
  assign out_tile_o   = emit ? tile : '0;
  assign busy_o       = (state_q != ST_IDLE);
  assign done_o       = done_q;
  assign err_early_o  = err_q;

endmodule

// File: tb/tb_layer1_conv_sched.sv
// Randomized bench for layer1_conv_sched against a timestamp-based transaction model.
module tb_layer1_conv_sched;
  import layer1_pkg::*;

  localparam int N_WORDS = GROUP_NUM * TILE_NUM;

  logic               clk = 1'b0;
  logic               rst_n, start, abort, conv_ready, out_ready;
  logic               w_rd_en, f_rd_en, conv_start, out_valid, busy, done, err_early;
  logic [W_AW-1:0]    w_rd_addr;
  logic [F_AW-1:0]    f_rd_addr;
  logic [GROUP_W-1:0] out_group;
  logic [TILE_W-1:0]  out_tile;

  always #5 clk = ~clk;

  layer1_conv_sched dut (
    .clk_in_i     (clk),
    .rst_n_i      (rst_n),
    .start_i      (start),
    .abort_i      (abort),
    .w_rd_en_o    (w_rd_en),
    .w_rd_addr_o  (w_rd_addr),
    .f_rd_en_o    (f_rd_en),
    .f_rd_addr_o  (f_rd_addr),
    .conv_start_o (conv_start),
    .conv_ready_i (conv_ready),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready),
    .out_group_o  (out_group),
    .out_tile_o   (out_tile),
    .busy_o       (busy),
    .done_o       (done),
    .err_early_o  (err_early)
  );

  int cyc = 0;
  int n_vec = 0;
  int n_err = 0;

  // model: current word plus the cycle its read burst began and the cycle the array answered
  bit m_busy = 0, m_err = 0;
  int m_grp = 0, m_til = 0;
  int burst_t = -1, ready_t = -1, done_t = -1;

  function automatic bit m_reading(int c);
    return m_busy && burst_t >= 0 && c >= burst_t && c < burst_t + FILTER_SIZE;
  endfunction
  function automatic bit m_waiting(int c);
    return m_busy && burst_t >= 0 && c >= burst_t + FILTER_SIZE && ready_t < 0;
  endfunction
  function automatic bit m_valid(int c);
    return m_busy && ready_t >= 0 && c >= ready_t + 1 + CAP_LAT;
  endfunction

  task automatic step_model(int c);
    bit wt, vl;
    wt = m_waiting(c);
    vl = m_valid(c);
    if (!rst_n) begin
      m_busy = 0; m_err = 0; burst_t = -1; ready_t = -1; m_grp = 0; m_til = 0;
    end else begin
      if (conv_ready && !wt) m_err = 1;
      if (abort) begin
        m_busy = 0; burst_t = -1; ready_t = -1;
      end else if (!m_busy) begin
        if (start) begin
          m_busy = 1; m_grp = 0; m_til = 0; burst_t = c + 1; ready_t = -1;
        end
      end else if (wt && conv_ready) begin
        ready_t = c;
      end else if (vl && out_ready) begin
        if (m_grp == GROUP_NUM - 1 && m_til == TILE_NUM - 1) begin
          m_busy = 0; burst_t = -1; ready_t = -1; done_t = c + 1;
        end else begin
          m_til++;
          if (m_til == TILE_NUM) begin m_til = 0; m_grp++; end
          burst_t = c + 1; ready_t = -1;
        end
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    step_model(cyc);
    cyc++;
  end

  task automatic chk(string name, longint act, longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  int  frame = 0;
  int  dut_words = 0;
  int  vrun = 0;
  int  last_tap0_c = -100;
  bit  first_rd_pending = 0;

  task automatic check_cycle(int c);
    bit rd, vl;
    int tap;
    rd  = m_reading(c);
    vl  = m_valid(c);
    tap = c - burst_t;
    chk("w_rd_en", w_rd_en, rd);
    chk("f_rd_en", f_rd_en, rd);
    if (rd) begin
      chk("w_rd_addr", w_rd_addr, m_grp * FILTER_SIZE + tap);
      chk("f_rd_addr", f_rd_addr, m_til * FILTER_SIZE + tap);
      if (m_grp == 2 && tap == 0)  chk("w_addr_g2_first", w_rd_addr, 50);
      if (m_grp == 2 && tap == 24) chk("w_addr_g2_last", w_rd_addr, 74);
      if (m_til == 5 && tap == 0)  chk("f_addr_t5_first", f_rd_addr, 125);
      if (m_til == 5 && tap == 24) chk("f_addr_t5_last", f_rd_addr, 149);
    end
    if (first_rd_pending && w_rd_en) begin
      chk("restart_w_addr", w_rd_addr, 0);
      chk("restart_f_addr", f_rd_addr, 0);
      first_rd_pending = 0;
    end
    chk("conv_start", conv_start, burst_t >= 0 && c == burst_t + RD_LAT);
    if (conv_start) chk("conv_start_lag", c - last_tap0_c, 1);
    if (w_rd_en && (int'(w_rd_addr) % FILTER_SIZE == 0)) last_tap0_c = c;
    chk("out_valid", out_valid, vl);
    if (vl) begin
      chk("out_group", out_group, m_grp);
      chk("out_tile", out_tile, m_til);
    end
    if (!m_busy) begin
      chk("idle_w_addr", w_rd_addr, 0);
      chk("idle_f_addr", f_rd_addr, 0);
      chk("idle_group", out_group, 0);
      chk("idle_tile", out_tile, 0);
    end
    chk("busy", busy, m_busy);
    chk("done", done, done_t == c);
    chk("err_early", err_early, m_err);
    if (out_valid) vrun++;
    if (out_valid && out_ready) begin
      dut_words++;
      if (frame == 1 && out_group == 0 && out_tile == 3) chk("hold_len_g0t3", vrun, 11);
      vrun = 0;
    end else if (!out_valid) begin
      vrun = 0;
    end
    if (done) chk("words_per_frame", dut_words, N_WORDS);
  endtask

  initial forever begin
    @(negedge clk);
    if (cyc >= 1) check_cycle(cyc);
  end

  // array and downstream responder
  int ready_at = -1;
  bit spur_req = 0, hold_arm = 0, rdy_rand = 0;
  int hold_left = 0, dmin = 3, dmax = 3;

  initial begin
    conv_ready = 0;
    out_ready  = 1;
    forever begin
      @(negedge clk);
      if (w_rd_en && (int'(w_rd_addr) % FILTER_SIZE == FILTER_SIZE - 1))
        ready_at = cyc + int'($urandom_range(dmax, dmin));
      if (abort || !rst_n) ready_at = -1;
      @(posedge clk);
      #1;
      conv_ready = (cyc == ready_at);
      if (spur_req && m_reading(cyc) && (cyc - burst_t) == 7) begin
        conv_ready = 1;
        spur_req   = 0;
      end
      if (hold_left > 0) begin
        out_ready = 0;
        hold_left--;
      end else if (hold_arm && m_valid(cyc) && m_grp == 0 && m_til == 3) begin
        hold_arm  = 0;
        hold_left = 9;
        out_ready = 0;
      end else begin
        out_ready = rdy_rand ? ($urandom_range(0, 1) == 1) : 1'b1;
      end
    end
  end

  bit rand_start = 0;

  task automatic pulse_start();
    start = 1;
    @(posedge clk);
    #1;
    start = 0;
  endtask

  task automatic wait_done(int bound);
    bit seen = 0;
    for (int i = 0; i < bound && !seen; i++) begin
      @(posedge clk);
      #1;
      start = rand_start && m_reading(cyc) && ($urandom_range(0, 99) < 5);
      if (done) seen = 1;
    end
    start = 0;
    if (!seen) begin
      n_err++;
      $display("FAIL done_timeout: no done within %0d cycles (frame %0d)", bound, frame);
    end
  endtask

  initial begin
    bit found;
    rst_n = 0; start = 0; abort = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    repeat (2) @(posedge clk);
    #1;

    frame = 1; hold_arm = 1; dut_words = 0;
    pulse_start();
    wait_done(30000);
    repeat (3) @(posedge clk);
    #1;

    frame = 2; rdy_rand = 1; dmin = 1; dmax = 5; dut_words = 0;
    pulse_start();
    found = 0;
    for (int i = 0; i < 20000 && !found; i++) begin
      @(posedge clk);
      #1;
      if (m_waiting(cyc) && m_grp == 4 && m_til == 10) found = 1;
    end
    if (!found) begin
      n_err++;
      $display("FAIL abort_point_timeout: g4 t10 WAIT not reached");
    end
    abort = 1;
    @(posedge clk);
    #1 abort = 0;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_valid", out_valid, 0);
    chk("abort_rd_en", w_rd_en, 0);
    @(posedge clk);
    #1;
    start = 1; abort = 1;
    repeat (3) @(posedge clk);
    #1 start = 0; abort = 0;
    @(negedge clk);
    chk("start_abort_busy", busy, 0);
    chk("err_clean_after_abort", err_early, 0);
    @(posedge clk);
    #1;

    frame = 3; first_rd_pending = 1; spur_req = 1; rand_start = 1; dut_words = 0;
    pulse_start();
    wait_done(40000);
    rand_start = 0;
    @(negedge clk);
    chk("err_sticky", err_early, 1);
    @(posedge clk);
    #1;

    frame = 4;
    pulse_start();
    repeat (100) @(posedge clk);
    #1 rst_n = 0;
    @(posedge clk);
    #1 rst_n = 1;
    @(negedge clk);
    chk("reset_err_clear", err_early, 0);
    chk("reset_busy", busy, 0);
    repeat (5) @(posedge clk);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/layer1_conv_sched.md
Name: layer1_conv_sched

Overview:
Sequencer for the layer-1 convolution array (4 filters x 16 spatial conv units, 5x5 taps streamed serially). It loops over filter groups and spatial tiles, issues tap-ordered reads to the feature-window and weight buffers, and pulses the array start. It then waits for the array ready and hands each registered result word downstream with a valid/ready handshake. It sits between the layer-1 buffers and the pooling/writeback stage.

Parameters:
FILTER_SIZE, 25, taps per window (5x5), streamed one per cycle
GROUP_NUM, 16, filter groups per layer (64 output channels / 4 filters per pass)
TILE_NUM, 36, spatial tiles per frame (16 conv positions each)
RD_LAT, 1, buffer read latency in cycles (1..3)
CAP_LAT, 1, cycles from conv_ready to registered array output being valid
W_AW, 9, weight buffer address width (must hold GROUP_NUM*FILTER_SIZE-1)
F_AW, 10, feature buffer address width (must hold TILE_NUM*FILTER_SIZE-1)

Ports:
clk_in  in  1  clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset
start  in  1  frame start request, sampled only in IDLE
abort  in  1  synchronous abort, highest priority after reset
w_rd_en  out  1  weight buffer read enable
w_rd_addr  out  W_AW  weight address = group*FILTER_SIZE + tap
f_rd_en  out  1  feature buffer read enable
f_rd_addr  out  F_AW  feature address = tile*FILTER_SIZE + tap
conv_start  out  1  one-cycle start pulse to conv array
conv_ready  in  1  conv array result-ready
out_valid  out  1  array output word valid for current (group, tile)
out_ready  in  1  downstream accepts word
out_group  out  4  group index of current word
out_tile  out  6  tile index of current word
busy  out  1  high from accepted start until done/abort
done  out  1  one-cycle pulse after last word accepted
err_early  out  1  sticky: conv_ready seen outside WAIT

Behaviour:
- Reset (rst_n=0 at a clock edge): state IDLE, all counters 0, every output 0, including err_early.
- States: IDLE, FETCH, WAIT, CAPT, EMIT.
- IDLE: start=1 -> FETCH, busy<=1, group=0, tile=0, tap=0.
- FETCH: FILTER_SIZE cycles with w_rd_en=f_rd_en=1, tap 0..FILTER_SIZE-1 in consecutive cycles, no bubbles. conv_start pulses exactly RD_LAT cycles after the tap-0 read cycle, so it aligns with tap-0 data. After tap FILTER_SIZE-1 -> WAIT. The read enables are 0 in every other state.
- WAIT: hold until conv_ready=1, then start a CAP_LAT-cycle counter in CAPT.
- CAPT: after CAP_LAT cycles -> EMIT with out_valid=1.
- EMIT: out_valid, out_group and out_tile stay stable until out_ready=1 (handshake = valid&ready in the same cycle). On handshake, advance: tile+1. On tile wrap (TILE_NUM-1 -> 0), group+1. If group=GROUP_NUM-1 and tile=TILE_NUM-1 -> IDLE, done=1 for one cycle, busy<=0. Otherwise -> FETCH next cycle.
- Counter order: tile inner, group outer. Total words per frame = GROUP_NUM*TILE_NUM = 576.
- Per-word minimum latency from FETCH entry to out_valid = FILTER_SIZE + (array latency) + CAP_LAT.
- abort=1 in any state: next state IDLE, out_valid, conv_start, read enables and busy go 0, no done pulse. abort and start together in IDLE: abort wins and start is ignored.
- start while busy is ignored.
- conv_ready=1 in any state other than WAIT sets err_early (sticky until reset) and does not change state.
- Address arithmetic is unsigned. Widths are checked by elaboration assertions against the parameter products.
- Reset mid-frame behaves like abort and also clears err_early.

Decomposition:
- Shared package layer1_pkg: FILTER_SIZE, GROUP_NUM, TILE_NUM, state encoding constants, and clog2-derived widths for group, tile and tap.
- One natural sub-module, layer1_tap_counter: nested tap/tile/group counter with wrap and last flags, reused by later layers.
- The FSM and handshake logic stay in layer1_conv_sched.

Test Plan:
- Reset then start, with the array model returning ready 3 cycles after the final tap and out_ready=1 always -> 576 words in order (g0 t0..t35, g1 t0..), done pulses once, busy low the next cycle.
- Addresses with RD_LAT=1 -> w_rd_addr for group 2 runs 50..74, f_rd_addr for tile 5 runs 125..149, and conv_start is 1 cycle after the tap-0 read.
- out_ready held 0 for 10 cycles on word g0 t3 -> out_valid stays 1 with group/tile stable, no new FETCH starts, and the word advances only on the handshake cycle.
- abort asserted in WAIT at g4 t10 -> next cycle IDLE with all outputs 0 and no done. A new start then begins at g0 t0.
- conv_ready pulsed during FETCH -> err_early=1 and stays 1; the frame still completes normally.
- start asserted while busy, and start+abort together in IDLE -> both ignored, state remains as before.
